cpu_bus_responder: RTL
======================

// Module: cpu_bus_responder
// PURPOSE
//  Memory-side responder for the 8-bit CPU data bus (write/read/address/data strobes).
//  Serves CPU LOAD/STORE with single-cycle RAM plus a memory-mapped peripheral page.
//  Peripherals: LED latch, prescaled free-running timer, and TX byte FIFO draining to a valid/ready stream.
//  Sits between the CPU and board I/O; the CPU samples read data in the same cycle it asserts read.
// PARAMETERS
//  RAM_DEPTH   224  RAM bytes mapped at 0x00..RAM_DEPTH-1; legal range 1..224
//  FIFO_DEPTH  4    TX FIFO entries; power of 2, >=2
//  PRESCALE    1    clk cycles per timer increment; >=1
// PORTS
//  clk       in   1  system clock, all state on rising edge
//  rst       in   1  asynchronous, active-low reset
//  write     in   1  CPU write strobe, one cycle per STORE
//  read      in   1  CPU read strobe, one cycle per LOAD
//  address   in   8  CPU byte address
//  din       in   8  write data from CPU
//  dout      out  8  read data to CPU, combinational from address
//  led       out  8  LED latch
//  tx_data   out  8  FIFO head byte
//  tx_valid  out  1  FIFO non-empty
//  tx_ready  in   1  downstream accepts tx_data
// BEHAVIOUR
//  Reset (rst=0, async): led=0, timer=0, prescaler=0, FIFO empty, overflow=0, tx_valid=0.
//  RAM contents are not reset.
//  Address map:
//    0x00..RAM_DEPTH-1  RAM; read/write
//    0xF0  LED          read/write
//    0xF1  TIMER        read = count; write = load
//    0xF2  TXDATA       write = push; read = 0x00
//    0xF3  STATUS       read = {5'b0, overflow, full, empty}; write (any data) clears overflow
//    all other addresses: read 0x00, writes ignored
//  Read path:
//    dout is combinational on address with zero latency, valid whether or not read=1.
//    Reads have no side effects.
//  Write path:
//    Writes take effect at the rising edge where write=1.
//    dout in that same cycle shows the pre-write value.
//    read and write both high: the write is performed.
//  Timer:
//    Prescaler counts 0..PRESCALE-1; timer increments by 1 when it wraps.
//    Timer is 8-bit and wraps 0xFF->0x00.
//    A TIMER write loads din and zeroes the prescaler; the write wins over the same-cycle increment.
//  FIFO pop: tx_valid && tx_ready at an edge.
//    tx_data is the head entry, combinational from storage.
//    tx_data is don't-care while empty.
//  FIFO push: TXDATA write.
//    Accepted if not full, or if full with a same-cycle pop; occupancy is unchanged in that case.
//    Full with no pop: byte dropped, overflow set (sticky until STATUS write or reset).
//    Push into an empty FIFO: tx_valid rises the next cycle (no bypass path).
//    Pointers are log2(FIFO_DEPTH) bits wide and wrap; a count of width log2(FIFO_DEPTH)+1 distinguishes full from empty.
//  Mid-operation reset: all FIFO contents are discarded immediately and tx_valid drops asynchronously.
// TESTING
//  1. Write 0x3C @0x10, then read @0x10: dout=0x3C in the read cycle.
//     Read @0xE5: 0x00.
//  2. Write 0xA5 @0xF0: led=0xA5 after that edge; read @0xF0 returns 0xA5.
//  3. Overflow and drain, tx_ready=0:
//     Push 0x11,0x22,0x33,0x44: STATUS=0x02.
//     Push 0x55: STATUS=0x06, 0x55 dropped.
//     Set tx_ready=1: 0x11,0x22,0x33,0x44 on 4 consecutive edges; then STATUS=0x05.
//     Write STATUS: STATUS=0x01.
//  4. PRESCALE=1: 10 edges after reset release, TIMER=0x0A.
//     Write 0xFE: reads 0xFE, 0xFF, 0x00, 0x01 over the next edges.
//  5. FIFO full, tx_ready=1, push 0x77 in the same cycle:
//     Head pops, 0x77 accepted, STATUS stays 0x02, overflow stays 0.
//  6. Two entries queued, led=0xFF, pull rst low between edges:
//     tx_valid=0 and led=0 immediately; STATUS=0x01 after release.

Source files
------------

// File: rtl/cpu_bus_responder_if.sv
// CPU data-bus and TX-stream signal bundle for cpu_bus_responder.
// slave = the responder side, master = the CPU/board side.
interface cpu_bus_responder_if;
    logic       write;
    logic       read;
    logic [7:0] address;
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] led;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport slave (
        input  write, read, address, din, tx_ready,
        output dout, led, tx_data, tx_valid
    );

    modport master (
        output write, read, address, din, tx_ready,
        input  dout, led, tx_data, tx_valid
    );
endinterface

// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the 8-bit CPU bus: single-cycle RAM plus a peripheral page
// holding an LED latch, a prescaled timer and a TX byte FIFO drained over valid/ready.
module cpu_bus_responder #(
    parameter int RAM_DEPTH  = 224,
    parameter int FIFO_DEPTH = 4,
    parameter int PRESCALE   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_bus_responder_if.slave    bus
);

    localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [7:0] ADDR_LED    = 8'hF0;
    localparam logic [7:0] ADDR_TIMER  = 8'hF1;
    localparam logic [7:0] ADDR_TXDATA = 8'hF2;
    localparam logic [7:0] ADDR_STATUS = 8'hF3;

    logic [7:0]        r_ram [RAM_DEPTH];
    logic [7:0]        r_fifo [FIFO_DEPTH];
    logic [7:0]        r_led;
    logic [7:0]        r_timer;
    logic [PS_W-1:0]   r_prescale;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    logic              w_ram_sel;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_wr_ram;
    logic              w_wr_led;
    logic              w_wr_timer;
    logic              w_wr_status;
    logic              w_push_req;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_empty;
    logic              w_full;
    logic              w_ps_wrap;
    logic [7:0]        w_dout;
    logic              w_unused;

    // Reads are side-effect free, so the read strobe carries no information here.
    assign w_unused    = bus.read;

    assign w_ram_sel   = ({1'b0, bus.address} < 9'(RAM_DEPTH));
    assign w_ram_idx   = bus.address[RAM_AW-1:0];
    assign w_wr_ram    = bus.write && w_ram_sel;
    assign w_wr_led    = bus.write && (bus.address == ADDR_LED);
    assign w_wr_timer  = bus.write && (bus.address == ADDR_TIMER);
    assign w_wr_status = bus.write && (bus.address == ADDR_STATUS);
    assign w_push_req  = bus.write && (bus.address == ADDR_TXDATA);

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop       = !w_empty && bus.tx_ready;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_drop      = w_push_req && w_full && !w_pop;
    assign w_ps_wrap   = (r_prescale == PS_W'(PRESCALE - 1));

    always_comb begin
        w_dout = 8'h00;
        if (w_ram_sel) begin
            w_dout = r_ram[w_ram_idx];
        end else begin
            case (bus.address)
                ADDR_LED:    w_dout = r_led;
                ADDR_TIMER:  w_dout = r_timer;
                ADDR_STATUS: w_dout = {5'b0, r_overflow, w_full, w_empty};
                default:     w_dout = 8'h00;
            endcase
        end
    end

    assign bus.dout     = w_dout;
    assign bus.led      = r_led;
    assign bus.tx_valid = !w_empty;
    assign bus.tx_data  = r_fifo[r_rd_ptr];

    // Storage arrays carry no reset; only the bookkeeping around them does.
    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_ram[w_ram_idx] <= bus.din;
        end
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led      <= 8'h00;
            r_timer    <= 8'h00;
            r_prescale <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_led) begin
                r_led <= bus.din;
            end

            // A TIMER load overrides the increment that would land on the same edge.
            if (w_wr_timer) begin
                r_timer    <= bus.din;
                r_prescale <= '0;
            end else if (w_ps_wrap) begin
                r_timer    <= r_timer + 8'd1;
                r_prescale <= '0;
            end else begin
                r_prescale <= r_prescale + PS_W'(1);
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_wr_status) begin
                r_overflow <= 1'b0;
            end
        end
    end

endmodule
